// File: rtl/rr_sync_reg_arbiter.sv
// Round-robin arbiter feeding a single registered output channel.
// One pending requester is granted per accept cycle. Its data slice is captured
// into the output register, which holds it until valid/ready completes.
// The pointer names the highest-priority index and moves just past each winner.
module rr_sync_reg_arbiter #(
  parameter  int WIDTH = 10,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*WIDTH-1:0]   data_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [WIDTH-1:0]        data_o,
  output logic [IDW-1:0]          src_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  logic [IDW-1:0]   ptr_r;
  logic [WIDTH-1:0] data_r;
  logic [IDW-1:0]   src_r;
  logic             valid_r;

  logic             accept_s;
  logic             found_s;
  logic [IDW-1:0]   winner_s;
  logic [NREQ-1:0]  onehot_s;
  logic [WIDTH-1:0] win_data_s;
  logic [IDW-1:0]   ptr_next_s;

  // Accept a new word when something is pending and the register is free or draining now.
  always_comb begin
    accept_s = (|req_i) && (!valid_r || ready_i);
  end

  // Scan from the pointer upward, wrapping explicitly at NREQ, and pick the first pending index.
  always_comb begin : arb_scan
    logic [IDW:0] idx_v;
    found_s  = 1'b0;
    winner_s = '0;
    idx_v    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_v = {1'b0, ptr_r} + (IDW+1)'(k);
      if (idx_v >= (IDW+1)'(NREQ)) begin
        idx_v = idx_v - (IDW+1)'(NREQ);
      end else begin
        idx_v = idx_v;
      end
      if (!found_s && req_i[idx_v[IDW-1:0]]) begin
        found_s  = 1'b1;
        winner_s = idx_v[IDW-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Decode the winner into a one-hot vector and select its data slice.
  always_comb begin
    onehot_s   = '0;
    win_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner_s == IDW'(i)) begin
        onehot_s[i] = 1'b1;
        win_data_s  = data_i[i*WIDTH +: WIDTH];
      end else begin
        onehot_s[i] = 1'b0;
      end
    end
  end

  // Next pointer sits just past the winner; the last index wraps back to zero.
  always_comb begin
    if (winner_s == IDW'(NREQ-1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = winner_s + IDW'(1);
    end
  end

  // Grant is combinational from req/ready and is suppressed while reset is held.
  always_comb begin
    if (accept_s && found_s && !rst_i) begin
      gnt_o = onehot_s;
    end else begin
      gnt_o = '0;
    end
  end

  // Output register and pointer: capture on accept, clear valid on a pure drain, else hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_r  <= '0;
      src_r   <= '0;
      valid_r <= 1'b0;
      ptr_r   <= '0;
    end else if (accept_s && found_s) begin
      data_r  <= win_data_s;
      src_r   <= winner_s;
      valid_r <= 1'b1;
      ptr_r   <= ptr_next_s;
    end else if (valid_r && ready_i) begin
      valid_r <= 1'b0;
    end else begin
      data_r  <= data_r;
      src_r   <= src_r;
      valid_r <= valid_r;
      ptr_r   <= ptr_r;
    end
  end

  assign data_o  = data_r;
  assign src_o   = src_r;
  assign valid_o = valid_r;

endmodule

// File: tb/tb_rr_sync_reg_arbiter.sv
// Table-driven bench for rr_sync_reg_arbiter (NREQ=4) plus a short NREQ=3 sequence.
module tb_rr_sync_reg_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [39:0] data;
  logic [3:0]  gnt;
  logic [9:0]  dout;
  logic [1:0]  src;
  logic        valid;
  logic        ready;

  logic        rst3;
  logic [2:0]  req3;
  logic [29:0] data3;
  logic [2:0]  gnt3;
  logic [9:0]  dout3;
  logic [1:0]  src3;
  logic        valid3;
  logic        ready3;

  int checks;
  int errors;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic       v;
    logic [9:0] d;
    logic [1:0] s;
  } vec_t;

  vec_t tbl[$];

  rr_sync_reg_arbiter #(.WIDTH(10), .NREQ(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data),
    .gnt_o(gnt), .data_o(dout), .src_o(src), .valid_o(valid), .ready_i(ready)
  );

  rr_sync_reg_arbiter #(.WIDTH(10), .NREQ(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst3), .req_i(req3), .data_i(data3),
    .gnt_o(gnt3), .data_o(dout3), .src_o(src3), .valid_o(valid3), .ready_i(ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; req = 4'b0000; ready = 1'b0;
    data = {10'h3C3, 10'h155, 10'h111, 10'h0A0};
    rst3 = 1'b1; req3 = 3'b000; ready3 = 1'b0;
    data3 = {10'h033, 10'h022, 10'h011};

    //                rst   req      rdy   gnt      v     data     src
    tbl.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 10'h000, 2'd0}); // reset
    tbl.push_back('{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 10'h155, 2'd2}); // single req
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 10'h155, 2'd2}); // drain
    tbl.push_back('{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 10'h111, 2'd1}); // load word
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 10'h000, 2'd0}); // reset with data held
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 10'h0A0, 2'd0}); // contention
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 10'h111, 2'd1});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 10'h155, 2'd2});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 10'h3C3, 2'd3});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 10'h0A0, 2'd0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 10'h111, 2'd1});
    for (int i = 0; i < 5; i++)                                          // backpressure
      tbl.push_back('{1'b0, 4'b1101, 1'b0, 4'b0000, 1'b1, 10'h111, 2'd1});
    tbl.push_back('{1'b0, 4'b1101, 1'b1, 4'b0100, 1'b1, 10'h155, 2'd2});
    tbl.push_back('{1'b0, 4'b1101, 1'b1, 4'b1000, 1'b1, 10'h3C3, 2'd3});
    tbl.push_back('{1'b0, 4'b1101, 1'b1, 4'b0001, 1'b1, 10'h0A0, 2'd0});
    tbl.push_back('{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 10'h3C3, 2'd3}); // grant to 3
    tbl.push_back('{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 10'h111, 2'd1}); // wrap and skip
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 10'h111, 2'd1});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 10'h111, 2'd1});
    tbl.push_back('{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 10'h3C3, 2'd3}); // load, ptr -> 0
    tbl.push_back('{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 10'h3C3, 2'd3}); // stall
    tbl.push_back('{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 10'h000, 2'd0}); // reset mid-stall
    tbl.push_back('{1'b0, 4'b0110, 1'b0, 4'b0010, 1'b1, 10'h111, 2'd1}); // first grant after reset

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; req = tbl[i].req; ready = tbl[i].rdy;
      #1;
      chk("gnt", i, 32'(gnt), 32'(tbl[i].gnt));
      @(posedge clk);
      #1;
      chk("valid", i, 32'(valid), 32'(tbl[i].v));
      chk("data", i, 32'(dout), 32'(tbl[i].d));
      chk("src", i, 32'(src), 32'(tbl[i].s));
    end

    @(negedge clk);
    rst = 1'b0; req = 4'b0000; ready = 1'b1;

    // NREQ=3: reset, then continuous requests must rotate 0,1,2,0,1,2,0 and never show 3
    @(negedge clk);
    rst3 = 1'b1; req3 = 3'b111; ready3 = 1'b1;
    #1;
    chk("gnt3_rst", 0, 32'(gnt3), 32'd0);
    @(posedge clk);
    #1;
    chk("valid3_rst", 0, 32'(valid3), 32'd0);
    for (int k = 0; k < 7; k++) begin
      logic [1:0] exp_src;
      logic [2:0] exp_gnt;
      exp_src = 2'(k % 3);
      exp_gnt = 3'b001 << exp_src;
      @(negedge clk);
      rst3 = 1'b0;
      #1;
      chk("gnt3", k, 32'(gnt3), 32'(exp_gnt));
      @(posedge clk);
      #1;
      chk("valid3", k, 32'(valid3), 32'd1);
      chk("src3", k, 32'(src3), 32'(exp_src));
      chk("data3", k, 32'(dout3), 32'(10'h011 * (exp_src + 10'd1)));
    end

    @(negedge clk);
    req3 = 3'b000;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_sync_reg_arbiter.md
# rr_sync_reg_arbiter

Round-robin arbiter that shares one registered WIDTH-bit output channel between NREQ requesters. Each cycle at most one pending request is granted. Its data is captured into the output register, which holds it until a downstream valid/ready handshake completes. The block sits in front of the synchronizing output register stage and makes it a fair, backpressure-aware shared resource.

## Interface
- WIDTH, 10: data width per requester and of the output register
- NREQ, 4: number of requesters, ≥2
- IDW, $clog2(NREQ): width of the source-ID field (derived, not overridden)
- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  reset, synchronous and active-high
- req_i  in  NREQ  per-requester request; bit i pending
- data_i  in  NREQ*WIDTH  requester data; slice i = data_i[i*WIDTH +: WIDTH]
- gnt_o  out  NREQ  one-hot grant; gnt_o[i]=1 means slice i is captured at this clock edge
- data_o  out  WIDTH  registered output data
- src_o  out  IDW  index of the requester whose data is in data_o
- valid_o  out  1  output register holds unconsumed data
- ready_i  in  1  downstream accepts data_o when valid_o && ready_i

## Operation
- State: output register (data_q, src_q, valid_q) and round-robin pointer ptr_q[IDW-1:0]. ptr_q is the highest-priority index.
- Accept condition: accept = (|req_i) && (!valid_q || ready_i). The register is free, or it is being drained this cycle.
- Arbitration is combinational:
  - Scan indices ptr_q, ptr_q+1, … wrapping modulo NREQ.
  - The first set req_i bit wins.
  - gnt_o = one-hot(winner) when accept, else all zeros.
- On an accept edge:
  - data_q <= winner's data_i slice.
  - src_q <= winner.
  - valid_q <= 1.
  - ptr_q <= (winner+1) mod NREQ. For winner = NREQ-1 this wraps to 0.
- On a non-accept edge:
  - If valid_q && ready_i, then valid_q <= 0.
  - Otherwise data_q, src_q and valid_q hold.
  - ptr_q holds.
- Requester contract:
  - Once asserted, req_i[i] and its data slice stay stable until gnt_o[i] is seen.
  - A requester may keep req_i[i] high after a grant to issue back-to-back words. It then re-enters arbitration at lowest priority.
- Fairness: with all requesters continuously requesting and ready_i=1, grants rotate 0,1,…,NREQ-1,0,… Any pending requester is granted within NREQ accept cycles.
- Non-power-of-2 NREQ: the pointer wrap is explicit (compare to NREQ-1). It must never reach an index ≥ NREQ.
- Reset (rst_i=1 at an edge):
  - data_q=0, src_q=0, valid_q=0, ptr_q=0.
  - This applies regardless of in-flight data; the current word is dropped.
  - While rst_i=1, gnt_o is forced to 0.

## Timing
- Reset values: data_o=0, src_o=0, valid_o=0, gnt_o=0.
- Latency: the accept edge gives valid_o=1 with the new data_o/src_o in the next cycle, so one cycle from grant to output.
- Throughput: one word per cycle while ready_i=1 and any req_i is set.
- Simultaneous drain and accept (valid_q && ready_i && |req_i):
  - The new word replaces the old one at the same edge.
  - valid_o stays 1 with no bubble.
- Backpressure (valid_q && !ready_i):
  - gnt_o=0.
  - data_o, src_o and ptr_q stay stable for the whole stall, however long.
- gnt_o has a combinational path from ready_i and req_i. Integrators must not loop gnt_o combinationally back into req_i.
- Reset mid-stall: valid_o=0 in the cycle after the reset edge. The first grant after reset goes to the lowest set index at or above 0.

## Test plan
- Reset: load a word, then hold rst_i=1 for 1 cycle with ready_i=0 -> data_o=0, src_o=0, valid_o=0, gnt_o=0 next cycle; ptr restarts at 0.
- Single requester: req_i=4'b0100, data slice 2=10'h155, ready_i=1 -> gnt_o=4'b0100 same cycle; next cycle valid_o=1, data_o=10'h155, src_o=2.
- Full contention: req_i=4'b1111 held, ready_i=1, distinct data per slice -> src_o sequence 0,1,2,3,0,1 on consecutive cycles with valid_o continuously 1.
- Backpressure: valid_o=1 with src_o=1, ready_i=0 for 5 cycles, req_i=4'b1101 -> gnt_o=0 and data_o/src_o stable for 5 cycles; when ready_i=1, grant goes to index 2, then 3, then 0.
- Pointer wrap and skip: after a grant to index 3, req_i=4'b0010 -> grant to 1, with no stale grant to 0 or 3.
- NREQ=3 build: req_i=3'b111 continuous -> src_o sequence 0,1,2,0; src_o never 3.
